// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side bundle for the shared program/data RAM arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_wdata;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              load_gnt;
  logic              data_gnt;
  logic              fetch_gnt;
  logic              data_rvalid;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  load_req, load_addr, load_wdata,
    input  data_req, data_we, data_addr, data_wdata,
    input  fetch_req, fetch_addr,
    output load_gnt, data_gnt, fetch_gnt,
    output data_rvalid, fetch_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output load_req, load_addr, load_wdata,
    output data_req, data_we, data_addr, data_wdata,
    output fetch_req, fetch_addr,
    input  load_gnt, data_gnt, fetch_gnt,
    input  data_rvalid, fetch_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: loader > data > fetch, with a
// starvation override that lets fetch win after MAX_WAIT losses.
module mem_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ_WAIT
  } state_t;

  typedef enum logic [1:0] {
    ID_NONE,
    ID_LOAD,
    ID_DATA,
    ID_FETCH
  } id_t;

  state_t     state;
  id_t        owner;
  id_t        win;
  logic [3:0] wait_cnt;
  logic       fetch_due;

  assign fetch_due = bus.fetch_req
                  && (wait_cnt == 4'(MAX_WAIT));

  always_comb begin
    win = ID_NONE;
    if (bus.load_req)
      win = ID_LOAD;
    else if (fetch_due)
      win = ID_FETCH;
    else if (bus.data_req)
      win = ID_DATA;
    else if (bus.fetch_req)
      win = ID_FETCH;
  end

  assign bus.busy = (state != IDLE);

  // mem_we/mem_addr/mem_wdata double as the request latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= ID_NONE;
      wait_cnt         <= '0;
      bus.load_gnt     <= 1'b0;
      bus.data_gnt     <= 1'b0;
      bus.fetch_gnt    <= 1'b0;
      bus.data_rvalid  <= 1'b0;
      bus.fetch_rvalid <= 1'b0;
      bus.rdata        <= '0;
      bus.mem_en       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
    end else begin
      bus.load_gnt     <= 1'b0;
      bus.data_gnt     <= 1'b0;
      bus.fetch_gnt    <= 1'b0;
      bus.data_rvalid  <= 1'b0;
      bus.fetch_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win != ID_NONE) begin
            state         <= ACCESS;
            owner         <= win;
            bus.mem_en    <= 1'b1;
            bus.load_gnt  <= (win == ID_LOAD);
            bus.data_gnt  <= (win == ID_DATA);
            bus.fetch_gnt <= (win == ID_FETCH);
            unique case (win)
              ID_LOAD: begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= bus.load_addr;
                bus.mem_wdata <= bus.load_wdata;
              end
              ID_DATA: begin
                bus.mem_we    <= bus.data_we;
                bus.mem_addr  <= bus.data_addr;
                bus.mem_wdata <= bus.data_wdata;
              end
              ID_FETCH: begin
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.fetch_addr;
                bus.mem_wdata <= '0;
              end
              default: ;
            endcase
            if (win == ID_FETCH || !bus.fetch_req)
              wait_cnt <= '0;
            else if (wait_cnt != 4'(MAX_WAIT))
              wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= bus.mem_we ? IDLE : READ_WAIT;
        end
        READ_WAIT: begin
          bus.rdata        <= bus.mem_rdata;
          bus.data_rvalid  <= (owner == ID_DATA);
          bus.fetch_rvalid <= (owner == ID_FETCH);
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
